// File: rtl/branch_sched.sv
// rtl/branch_sched.sv - ID-stage branch scheduler: RAW stall, resolve, redirect, delay-slot tracking
module branch_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_pc,
  input  logic             ex_wr_en,
  input  logic [4:0]       ex_wr_reg,
  input  logic             ex_is_load,
  input  logic             mem_wr_en,
  input  logic [4:0]       mem_wr_reg,
  input  logic             mem_is_load,
  input  logic             cmpout,
  output logic [31:0]      cmp_instr,
  output logic             stall,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             ds_error,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {S_IDLE, S_STALL, S_SLOT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_taken_count;
  logic [CNT_W-1:0] r_stall_count;
  logic             r_ds_error;

  logic [5:0]       w_op;
  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic             w_is_branch;
  logic             w_use_rt;
  logic             w_haz_rs;
  logic             w_haz_rt;
  logic             w_hazard;
  logic             w_resolve;
  logic             w_ds_hit;

  assign w_op = id_instr[31:26];
  assign w_rs = id_instr[25:21];
  assign w_rt = id_instr[20:16];

  // Decode the branch class and whether rt is a source operand
  always_comb begin
    w_is_branch = 1'b0;
    w_use_rt    = 1'b0;
    case (w_op)
      6'b000100, 6'b000101: begin
        w_is_branch = 1'b1;
        w_use_rt    = 1'b1;
      end
      6'b000110, 6'b000111: w_is_branch = 1'b1;
      6'b000001:            w_is_branch = (w_rt == 5'd0) || (w_rt == 5'd1);
      default:              w_is_branch = 1'b0;
    endcase
  end

  // Any result still in EX, or a load still in MEM, is not yet usable by the ID comparator
  assign w_haz_rs = (w_rs != 5'd0) &&
                    ((ex_wr_en && (ex_wr_reg == w_rs)) ||
                     (mem_wr_en && mem_is_load && (mem_wr_reg == w_rs)));
  assign w_haz_rt = w_use_rt && (w_rt != 5'd0) &&
                    ((ex_wr_en && (ex_wr_reg == w_rt)) ||
                     (mem_wr_en && mem_is_load && (mem_wr_reg == w_rt)));
  assign w_hazard = w_haz_rs || w_haz_rt;

  assign redirect_pc = id_pc + 32'd4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state and outputs; everything is forced quiet while reset is held
  always_comb begin
    w_next         = r_state;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    cmp_instr      = 32'd0;
    w_resolve      = 1'b0;
    w_ds_hit       = 1'b0;
    case (r_state)
      S_SLOT: begin
        if (id_valid) begin
          w_next   = S_IDLE;
          w_ds_hit = w_is_branch;
        end
      end
      default: begin
        if (id_valid && w_is_branch) begin
          if (w_hazard) begin
            stall  = 1'b1;
            w_next = S_STALL;
          end else begin
            w_resolve      = 1'b1;
            cmp_instr      = id_instr;
            redirect_valid = cmpout;
            w_next         = cmpout ? S_SLOT : S_IDLE;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
    endcase
    if (!reset_n) begin
      w_next         = S_IDLE;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      cmp_instr      = 32'd0;
      w_resolve      = 1'b0;
      w_ds_hit       = 1'b0;
    end
  end

  // Saturating statistics and the sticky delay-slot error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_br_count    <= '0;
      r_taken_count <= '0;
      r_stall_count <= '0;
      r_ds_error    <= 1'b0;
    end else begin
      if (w_resolve && (r_br_count != CNT_MAX))
        r_br_count <= r_br_count + CNT_ONE;
      if (w_resolve && cmpout && (r_taken_count != CNT_MAX))
        r_taken_count <= r_taken_count + CNT_ONE;
      if (stall && (r_stall_count != CNT_MAX))
        r_stall_count <= r_stall_count + CNT_ONE;
      if (w_ds_hit)
        r_ds_error <= 1'b1;
    end
  end

  assign br_count    = r_br_count;
  assign taken_count = r_taken_count;
  assign stall_count = r_stall_count;
  assign ds_error    = r_ds_error;

endmodule
